// File: rtl/ifetch_unit_pkg.sv
// ifetch_unit_pkg
//   Shared constants and helpers for the instruction fetch unit.
//   INST_NOP            : instruction presented when no fetched word is valid
//   DEFAULT_RESET_ADDR  : default first fetch address after reset
//   fetch_entry_t       : one prefetch FIFO entry, {address, instruction}
package ifetch_unit_pkg;

  localparam logic [31:0] INST_NOP           = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;
  localparam int unsigned ENTRY_W            = 64;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } fetch_entry_t;

  // Instruction fetches are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // Next sequential word address; wraps modulo 2^32.
  function automatic logic [31:0] next_word(input logic [31:0] a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/ifetch_unit_inst_fifo.sv
// inst_fifo
//   Small synchronous FIFO holding prefetched {addr, inst} entries.
//   The head entry is read combinationally so the fetch unit can present it
//   to IF/ID in the same cycle it becomes valid.
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   flush      : empty the FIFO (overrides push and pop)
//   push       : write push_data at the tail
//   push_data  : entry to write
//   pop        : remove the head entry (ignored when empty)
//   head_data  : current head entry (meaningful only when count != 0)
//   count      : number of valid entries, 0..DEPTH
module inst_fifo
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head_data,
  output logic [CNT_W-1:0]   count
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               wr_en;
  logic               rd_en;

  assign wr_en = push && !flush;
  assign rd_en = pop && !flush && (count_reg != '0);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (wr_en) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (rd_en) rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      count_next = count_reg + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Data storage carries no reset; only entries covered by count are read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= push_data;
  end

  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;

  // The fetch unit's credit scheme must never push into a full FIFO
  // unless the head leaves in the same cycle.
  assert property (@(posedge clk) disable iff (!rst)
                   !(wr_en && !rd_en && (count_reg == CNT_W'(DEPTH))));

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit
//   Instruction fetch unit. Owns the PC, issues in-order word requests to
//   instruction memory (req/gnt, in-order rvalid responses), buffers the
//   returned words in a prefetch FIFO and presents the FIFO head to IF/ID.
//   A taken jump flushes the FIFO, reloads the PC and discards every word
//   still in flight.
// Ports
//   clk, rst        : clock; asynchronous active-low reset
//   jump_en_i       : taken redirect from execute
//   jump_addr_i     : redirect target (low two bits ignored)
//   hold_i          : downstream stall, head must not be consumed
//   imem_req_o      : fetch request valid
//   imem_addr_o     : fetch word address
//   imem_gnt_i      : request accepted this cycle
//   imem_rvalid_i   : response valid (in request order)
//   imem_rdata_i    : response instruction word
//   inst_o          : head instruction, INST_NOP when not valid
//   inst_addr_o     : head address, 0 when not valid
//   inst_valid_o    : head valid
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]      fetch_pc_reg, fetch_pc_next;
  logic [31:0]      resp_pc_reg, resp_pc_next;
  logic [CNT_W-1:0] outstanding_reg, outstanding_next;
  logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;

  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_head_raw;
  fetch_entry_t       head_entry;
  fetch_entry_t       push_entry;
  logic               push;
  logic               pop;
  logic               issue;
  logic               dropping;
  logic [CNT_W:0]     credit_used;
  logic [31:0]        jump_target;

  assign jump_target = word_align(jump_addr_i);
  assign dropping    = imem_rvalid_i && (drop_cnt_reg != '0);

  // A jump discards the same-cycle response and pre-empts any pop.
  assign push = imem_rvalid_i && (drop_cnt_reg == '0) && !jump_en_i;
  assign pop  = inst_valid_o && !hold_i && !jump_en_i;

  // Slots committed = buffered words + words in flight. The entry leaving
  // this cycle is credited back immediately so a zero-wait memory sustains
  // one instruction per cycle with only two slots; the total can still never
  // exceed FIFO_DEPTH after the edge, so the FIFO cannot overflow.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_reg} - (CNT_W+1)'(pop);

  // Gating with rst keeps the request low while reset is held.
  assign imem_req_o  = rst && !jump_en_i && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign imem_addr_o = fetch_pc_reg;
  assign issue       = imem_req_o && imem_gnt_i;

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    resp_pc_next     = resp_pc_reg;
    outstanding_next = outstanding_reg + CNT_W'(issue) - CNT_W'(imem_rvalid_i);
    drop_cnt_next    = drop_cnt_reg;
    if (jump_en_i) begin
      fetch_pc_next = jump_target;
      resp_pc_next  = jump_target;
      // Everything still in flight after this cycle belongs to the old path.
      drop_cnt_next = outstanding_reg - CNT_W'(imem_rvalid_i);
    end else begin
      if (issue)    fetch_pc_next = next_word(fetch_pc_reg);
      if (push)     resp_pc_next  = next_word(resp_pc_reg);
      if (dropping) drop_cnt_next = drop_cnt_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_reg    <= RESET_ADDR;
      resp_pc_reg     <= RESET_ADDR;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
    end
  end

  assign push_entry = '{addr: resp_pc_reg, inst: imem_rdata_i};

  inst_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_inst_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (jump_en_i),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .head_data(fifo_head_raw),
    .count    (fifo_count)
  );

  assign head_entry   = fetch_entry_t'(fifo_head_raw);
  assign inst_valid_o = (fifo_count != '0);
  assign inst_o       = inst_valid_o ? head_entry.inst : INST_NOP;
  assign inst_addr_o  = inst_valid_o ? head_entry.addr : 32'h0;

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;
  import ifetch_unit_pkg::*;

  localparam int          DEPTH   = 2;
  localparam logic [31:0] XOR_PAT = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic        hold = 1'b0;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        inst_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       mem_q[$];
  logic [31:0] exp_q[$];
  bit          rand_mode = 1'b0;
  int          lat_cfg   = 1;
  int          last_due  = 0;

  ifetch_unit #(
    .RESET_ADDR(32'h0000_0000),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_en_i    (jump_en),
    .jump_addr_i  (jump_addr),
    .hold_i       (hold),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_gnt_i   (gnt),
    .imem_rvalid_i(rvalid),
    .imem_rdata_i (rdata),
    .inst_o       (inst),
    .inst_addr_o  (inst_addr),
    .inst_valid_o (inst_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory model: word = address ^ XOR_PAT, in-order responses.
  initial begin
    int    lat;
    int    due;
    pend_t p;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mem_q.delete();
        last_due = 0;
      end else if (imem_req && gnt) begin
        lat = rand_mode ? int'($urandom_range(4, 1)) : lat_cfg;
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        p.addr = imem_addr;
        p.due  = due;
        mem_q.push_back(p);
        n_checks++;
        if (mem_q.size() > DEPTH) begin
          n_fail++;
          $display("FAIL outstanding_bound: got %0d expected <= %0d", mem_q.size(), DEPTH);
        end
      end
      @(posedge clk);
      #1;
      rvalid = 1'b0;
      rdata  = 32'h0;
      gnt    = rand_mode ? 1'($urandom_range(1, 0)) : 1'b1;
      if (rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        rvalid = 1'b1;
        rdata  = mem_q[0].addr ^ XOR_PAT;
        void'(mem_q.pop_front());
      end
    end
  end

  // Scoreboard monitor: compares every consumed instruction.
  initial begin
    logic [31:0] ea;
    forever begin
      @(negedge clk);
      if (rst && inst_valid && !hold && !jump_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_inst: got addr %h expected none", inst_addr);
        end else begin
          ea = exp_q.pop_front();
          chk("inst_addr", inst_addr, ea);
          chk("inst_data", inst, ea ^ XOR_PAT);
          $display("txn cycle %0d: addr=%h inst=%h", cyc, inst_addr, inst);
        end
      end
      if (!inst_valid) begin
        chk("idle_inst", inst, INST_NOP);
        chk("idle_addr", inst_addr, 32'h0);
      end
    end
  end

  task automatic drain_and_freeze(input string name, input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      tick();
      n++;
    end
    hold = 1'b1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d left expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int n;
    #1 rst = 1'b0;

    // ---- Reset values and zero-wait streaming with hold ----
    repeat (3) tick();
    #2;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_inst", inst, INST_NOP);
    chk("rst_inst_addr", inst_addr, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(4 * i));
    rst = 1'b1;                                         // cycle 0
    tick();                                             // cycle 1
    tick(); #2;                                         // cycle 2
    chk("lat_valid", 32'(inst_valid), 32'h1);
    chk("lat_addr0", inst_addr, 32'h0);
    chk("lat_data0", inst, 32'h0 ^ XOR_PAT);
    tick(); #2;
    chk("seq_addr4", inst_addr, 32'h4);
    tick(); hold = 1'b1; #2;                            // cycle 4
    chk("hold_addr_c4", inst_addr, 32'h8);
    chk("hold_req_c4", 32'(imem_req), 32'h0);
    for (int k = 0; k < 2; k++) begin                   // cycles 5, 6
      tick(); #2;
      chk("hold_addr", inst_addr, 32'h8);
      chk("hold_inst", inst, 32'h8 ^ XOR_PAT);
      chk("hold_valid", 32'(inst_valid), 32'h1);
      chk("hold_req", 32'(imem_req), 32'h0);
    end
    tick(); hold = 1'b0; #2;                            // cycle 7
    chk("resume_req", 32'(imem_req), 32'h1);
    chk("resume_imem_addr", imem_addr, 32'h10);
    drain_and_freeze("stream", 40);
    repeat (6) tick();

    // ---- Jump with two requests in flight ----
    lat_cfg = 5;
    jump_addr = 32'h80; jump_en = 1'b1; #2;
    chk("jump_req_low", 32'(imem_req), 32'h0);
    tick(); jump_en = 1'b0; #2;
    chk("jump_valid_n1", 32'(inst_valid), 32'h0);
    chk("jump_req_n1", 32'(imem_req), 32'h1);
    chk("jump_addr_n1", imem_addr, 32'h80);
    tick(); #2;
    chk("jump_addr_n2", imem_addr, 32'h84);
    tick(); #2;
    chk("credit_stop", 32'(imem_req), 32'h0);
    chk("inflight_2", 32'(mem_q.size()), 32'h2);
    lat_cfg = 1;
    jump_addr = 32'h100; jump_en = 1'b1; hold = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h100 + 32'(4 * i));
    tick(); jump_en = 1'b0;
    drain_and_freeze("jump100", 40);
    repeat (6) tick();

    // ---- Jump to unaligned target coincident with hold and rvalid ----
    lat_cfg = 2;
    jump_addr = 32'h40; jump_en = 1'b1;
    tick(); jump_en = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin
      tick();
      n++;
    end
    chk("rvalid_seen", 32'(rvalid), 32'h1);
    jump_addr = 32'h203; jump_en = 1'b1; #2;
    chk("j203_req_low", 32'(imem_req), 32'h0);
    tick(); jump_en = 1'b0; #2;
    chk("j203_valid", 32'(inst_valid), 32'h0);
    chk("j203_req", 32'(imem_req), 32'h1);
    chk("j203_addr", imem_addr, 32'h200);
    tick(); #2;
    chk("j203_drop", 32'(inst_valid), 32'h0);
    lat_cfg = 1;
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    hold = 1'b0;
    drain_and_freeze("jump200", 40);
    repeat (6) tick();

    // ---- Random grant stalls, 1-4 cycle latency, random hold ----
    rand_mode = 1'b1;
    jump_addr = 32'h1000; jump_en = 1'b1;
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h1000 + 32'(4 * i));
    tick(); jump_en = 1'b0; hold = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
      hold = (exp_q.size() == 0) ? 1'b1 : ($urandom_range(3, 0) == 0);
    end
    drain_and_freeze("random", 1);
    rand_mode = 1'b0;
    repeat (10) tick();

    // ---- Reset mid-stream ----
    jump_addr = 32'h300; jump_en = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h300 + 32'(4 * i));
    tick(); jump_en = 1'b0; hold = 1'b0;
    n = 0;
    while (exp_q.size() > 2 && n < 40) begin
      tick();
      n++;
    end
    chk("midstream_progress", 32'(exp_q.size()), 32'h2);
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(inst_valid), 32'h0);
    chk("arst_inst", inst, INST_NOP);
    chk("arst_inst_addr", inst_addr, 32'h0);
    chk("arst_req", 32'(imem_req), 32'h0);
    chk("arst_imem_addr", imem_addr, 32'h0);
    exp_q.delete();
    tick();
    tick();
    for (int i = 0; i < 3; i++) exp_q.push_back(32'(4 * i));
    rst = 1'b1; #2;
    chk("restart_req", 32'(imem_req), 32'h1);
    chk("restart_addr", imem_addr, 32'h0);
    drain_and_freeze("restart", 30);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
